// File: rtl/data_buffer_pkg.sv
// Shared definitions for the byte-wide endpoint FIFO: depth, occupancy width
// and the AHB transfer size code.
package data_buffer_pkg;

  localparam int BUF_DEPTH = 64;
  localparam int OCC_W     = 7;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_1    = 2'd1,
    SZ_2    = 2'd2,
    SZ_4    = 2'd3
  } size_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] code);
    case (size_e'(code))
      SZ_1:    return 3'd1;
      SZ_2:    return 3'd2;
      SZ_4:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/buffer_byte_lanes.sv
// Four-byte show-ahead window starting at the read pointer; lanes beyond the
// current occupancy read as zero so an empty or short buffer never leaks stale bytes.
module buffer_byte_lanes
  import data_buffer_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [7:0]       mem [DEPTH],
  input  logic [PW-1:0]    rd_ptr,
  input  logic [OCC_W-1:0] count,
  output logic [31:0]      window
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [PW-1:0] idx;
      // Pointer arithmetic truncates to PW bits, giving the wrap across DEPTH-1 -> 0.
      assign idx = rd_ptr + PW'(gi);
      assign window[8*gi +: 8] = (count > OCC_W'(gi)) ? mem[idx] : 8'h00;
    end
  endgenerate

endmodule

// File: rtl/data_buffer.sv
// Circular byte FIFO between the AHB slave (1/2/4-byte access) and the USB
// packet engines (1 byte), with drop-on-overflow and occupancy reporting.
module data_buffer
  import data_buffer_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic [1:0]       store_tx_data,
  input  logic [31:0]      tx_data,
  input  logic [1:0]       get_rx_data,
  output logic [31:0]      rx_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  input  logic             store_rx_packet_data,
  input  logic [7:0]       rx_packet_data,
  input  logic             get_tx_packet_data,
  output logic [7:0]       tx_packet_data,
  output logic             buffer_overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [OCC_W-1:0] count_reg, count_next;
  logic             overflow_reg, overflow_next;

  logic [2:0]       ahb_push_n, ahb_pop_n, popped, req, accepted;
  logic [OCC_W:0]   free;
  logic [7:0]       stream [5];

  // Push stream: AHB lanes in ascending order, USB byte right after them.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_stream
      assign stream[gi] = (3'(gi) < ahb_push_n) ? tx_data[8*gi +: 8] : rx_packet_data;
    end
  endgenerate
  assign stream[4] = rx_packet_data;

  always_comb begin
    ahb_push_n    = size_bytes(store_tx_data);
    ahb_pop_n     = size_bytes(get_rx_data);
    popped        = 3'd0;
    // An AHB pop masks any simultaneous USB pop.
    if (ahb_pop_n != 3'd0) begin
      popped = (OCC_W'(ahb_pop_n) > count_reg) ? count_reg[2:0] : ahb_pop_n;
    end else if (get_tx_packet_data && count_reg != '0) begin
      popped = 3'd1;
    end
    free          = (OCC_W+1)'(DEPTH) - {1'b0, count_reg} + (OCC_W+1)'(popped);
    req           = ahb_push_n + {2'b00, store_rx_packet_data};
    overflow_next = ({{(OCC_W-2){1'b0}}, req} > free);
    accepted      = overflow_next ? free[2:0] : req;
    rd_ptr_next   = rd_ptr_reg + PW'(popped);
    wr_ptr_next   = wr_ptr_reg + PW'(accepted);
    count_next    = count_reg - OCC_W'(popped) + OCC_W'(accepted);
  end

  // Storage is never reset or cleared; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (n_rst && !clear) begin
      for (int k = 0; k < 5; k++) begin
        if (3'(k) < accepted) begin
          mem[wr_ptr_reg + PW'(k)] <= stream[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  buffer_byte_lanes #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_lanes (
    .mem    (mem),
    .rd_ptr (rd_ptr_reg),
    .count  (count_reg),
    .window (rx_data)
  );

  assign tx_packet_data   = rx_data[7:0];
  assign buffer_occupancy = count_reg;
  assign buffer_overflow  = overflow_reg;

endmodule

// File: tb/tb_data_buffer.sv
// Directed bench for data_buffer: push/pop sizes, overflow at full, wrap,
// clear priority, AHB-over-USB pop arbitration and reset.
module tb_data_buffer;
  import data_buffer_pkg::*;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             clear = 1'b0;
  logic [1:0]       store_tx_data = 2'd0;
  logic [31:0]      tx_data = 32'd0;
  logic [1:0]       get_rx_data = 2'd0;
  logic             store_rx_packet_data = 1'b0;
  logic [7:0]       rx_packet_data = 8'd0;
  logic             get_tx_packet_data = 1'b0;
  logic [31:0]      rx_data;
  logic [OCC_W-1:0] buffer_occupancy;
  logic [7:0]       tx_packet_data;
  logic             buffer_overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_buffer #(.DEPTH(64)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .rx_data              (rx_data),
    .buffer_occupancy     (buffer_occupancy),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_overflow      (buffer_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic idle();
    clear                = 1'b0;
    store_tx_data        = 2'd0;
    tx_data              = 32'd0;
    get_rx_data          = 2'd0;
    store_rx_packet_data = 1'b0;
    rx_packet_data       = 8'd0;
    get_tx_packet_data   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(input logic [1:0] sz, input logic [31:0] d);
    store_tx_data = sz;
    tx_data       = d;
    step();
  endtask

  task automatic flush();
    clear = 1'b1;
    step();
  endtask

  initial begin
    logic [7:0] b;
    idle();
    n_rst = 1'b0;
    step();
    step();
    check("rst_occ", 32'(buffer_occupancy), 32'd0);
    check("rst_rx", rx_data, 32'h0);
    check("rst_txpkt", 32'(tx_packet_data), 32'h0);
    check("rst_ovf", 32'(buffer_overflow), 32'd0);
    n_rst = 1'b1;

    // 4-byte store
    push(2'd3, 32'h44332211);
    check("st4_occ", 32'(buffer_occupancy), 32'd4);
    check("st4_rx", rx_data, 32'h44332211);
    check("st4_txpkt", 32'(tx_packet_data), 32'h11);

    // reset wins over a concurrent store and discards content
    n_rst = 1'b0;
    store_tx_data = 2'd3;
    tx_data = 32'h99887766;
    step();
    n_rst = 1'b1;
    check("midrst_occ", 32'(buffer_occupancy), 32'd0);
    check("midrst_rx", rx_data, 32'h0);

    // store then 1-byte get: show-ahead before the edge, advanced after
    push(2'd3, 32'hDDCCBBAA);
    get_rx_data = 2'd1;
    #1;
    check("get1_pre", rx_data, 32'hDDCCBBAA);
    step();
    check("get1_post", rx_data, 32'h00DDCCBB);
    check("get1_occ", 32'(buffer_occupancy), 32'd3);

    // fill to 62, then a 4-byte store keeps 2 bytes and pulses overflow
    flush();
    check("clr_occ", 32'(buffer_occupancy), 32'd0);
    for (int i = 0; i < 15; i++) begin
      push(2'd3, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    end
    push(2'd2, 32'h00003D3C);
    check("fill_occ", 32'(buffer_occupancy), 32'd62);
    check("fill_ovf", 32'(buffer_overflow), 32'd0);
    push(2'd3, 32'h41403F3E);
    check("full_occ", 32'(buffer_occupancy), 32'd64);
    check("full_ovf", 32'(buffer_overflow), 32'd1);
    check("full_head", 32'(tx_packet_data), 32'h00);

    // full with a matching pop: store is accepted, no overflow
    store_tx_data = 2'd1;
    tx_data = 32'h000000AA;
    get_rx_data = 2'd1;
    #1;
    check("fullpp_pre", rx_data, 32'h03020100);
    step();
    check("fullpp_occ", 32'(buffer_occupancy), 32'd64);
    check("fullpp_ovf", 32'(buffer_overflow), 32'd0);
    check("fullpp_rx", rx_data, 32'h04030201);

    // drain 60 bytes in 4-byte pops, then read across the 63 -> 0 wrap
    for (int j = 0; j < 15; j++) begin
      b = 8'(1 + 4*j);
      get_rx_data = 2'd3;
      #1;
      check($sformatf("drain%0d", j), rx_data, {b + 8'd3, b + 8'd2, b + 8'd1, b});
      step();
    end
    check("wrap_occ", 32'(buffer_occupancy), 32'd4);
    check("wrap_rx", rx_data, 32'hAA3F3E3D);
    get_rx_data = 2'd3;
    step();
    check("empty_occ", 32'(buffer_occupancy), 32'd0);
    check("empty_rx", rx_data, 32'h0);

    // USB push with AHB pop of 2 at occupancy 1
    flush();
    push(2'd1, 32'hFFFFFF77);
    check("one_occ", 32'(buffer_occupancy), 32'd1);
    check("one_rx", rx_data, 32'h00000077);
    store_rx_packet_data = 1'b1;
    rx_packet_data = 8'h5A;
    get_rx_data = 2'd2;
    #1;
    check("usbpush_pre", rx_data, 32'h00000077);
    step();
    check("usbpush_occ", 32'(buffer_occupancy), 32'd1);
    check("usbpush_head", 32'(tx_packet_data), 32'h5A);
    check("usbpush_ovf", 32'(buffer_overflow), 32'd0);

    // clear beats a concurrent store at occupancy 10
    flush();
    push(2'd3, 32'h03020100);
    push(2'd3, 32'h07060504);
    push(2'd2, 32'h00000908);
    check("ten_occ", 32'(buffer_occupancy), 32'd10);
    clear = 1'b1;
    store_tx_data = 2'd3;
    tx_data = 32'hCAFEBABE;
    step();
    check("clrst_occ", 32'(buffer_occupancy), 32'd0);
    check("clrst_rx", rx_data, 32'h0);
    check("clrst_ovf", 32'(buffer_overflow), 32'd0);

    // AHB get and USB get together: only the AHB pop happens
    push(2'd2, 32'h00002221);
    push(2'd1, 32'h00000023);
    check("three_occ", 32'(buffer_occupancy), 32'd3);
    get_rx_data = 2'd1;
    get_tx_packet_data = 1'b1;
    #1;
    check("arb_pre", 32'(tx_packet_data), 32'h21);
    step();
    check("arb_occ", 32'(buffer_occupancy), 32'd2);
    check("arb_rx", rx_data, 32'h00002322);

    // popping an empty buffer is harmless
    flush();
    get_rx_data = 2'd3;
    #1;
    check("popempty_rx", rx_data, 32'h0);
    step();
    get_tx_packet_data = 1'b1;
    step();
    check("popempty_occ", 32'(buffer_occupancy), 32'd0);

    // five bytes in one cycle: AHB lanes first, USB byte last
    store_tx_data = 2'd3;
    tx_data = 32'h04030201;
    store_rx_packet_data = 1'b1;
    rx_packet_data = 8'h05;
    step();
    check("five_occ", 32'(buffer_occupancy), 32'd5);
    check("five_rx", rx_data, 32'h04030201);
    get_rx_data = 2'd3;
    step();
    check("five_tail", 32'(tx_packet_data), 32'h05);
    get_tx_packet_data = 1'b1;
    step();
    check("five_occ_end", 32'(buffer_occupancy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_buffer.md
# data_buffer

Byte-wide circular FIFO shared by the AHB slave and the USB RX/TX packet engines. It holds endpoint payload: AHB writes it for transmission, or the RX engine fills it for the host to read. The AHB side moves 1, 2 or 4 bytes per cycle. The USB side moves 1 byte per cycle. The block reports occupancy back to the AHB slave's status map.

## Interface
Parameters:
- DEPTH, 64, capacity in bytes; must be a power of two.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- n_rst  in  1  reset; synchronous, active-low.
- clear  in  1  flush request from the AHB slave.
- store_tx_data  in  2  AHB push size: 0 none, 1 one byte, 2 two bytes, 3 four bytes.
- tx_data  in  32  AHB push data; little-endian, so [7:0] is pushed first.
- get_rx_data  in  2  AHB pop size, same encoding as store_tx_data.
- rx_data  out  32  show-ahead view of the 4 head bytes; [7:0] is the head.
- buffer_occupancy  out  7  bytes currently held, 0..DEPTH.
- store_rx_packet_data  in  1  RX engine pushes one byte.
- rx_packet_data  in  8  RX byte.
- get_tx_packet_data  in  1  TX engine pops one byte.
- tx_packet_data  out  8  head byte, show-ahead.
- buffer_overflow  out  1  one-cycle pulse when pushed bytes are dropped.

## Operation
- Storage: DEPTH×8 register array, 6-bit rd_ptr and wr_ptr that wrap modulo DEPTH, and a 7-bit count register. buffer_occupancy = count.
- rx_data byte k is the byte at mem[rd_ptr+k] if k < count, otherwise 0x00. tx_packet_data is rx_data[7:0]. Both are combinational from state.
- Pushes in one cycle are applied in this order:
  - AHB bytes first, in ascending lane order.
  - Then the USB byte.
  - At most 5 bytes total.
- Pushes beyond free space (DEPTH − count + bytes popped this cycle) are dropped, and buffer_overflow pulses for one cycle. Bytes that fit are kept in order.
- Pops:
  - AHB pop removes min(n, count) bytes.
  - USB pop removes min(1, count).
  - Popping when empty is harmless and returns 0x00.
- Simultaneous AHB pop and USB pop is illegal. The AHB pop wins and the USB pop is ignored.
- Push and pop in the same cycle are both honoured: count_next = count − popped + accepted. Pops see the state before the edge, so a byte pushed this cycle cannot be popped this cycle.
- clear has top priority. On the next edge rd_ptr = wr_ptr = 0 and count = 0, and every other request that cycle is discarded. Array contents are left unchanged.

## Timing
- Reset (n_rst low at an edge):
  - Pointers and count go to 0, and buffer_overflow goes to 0.
  - rx_data, tx_packet_data and buffer_occupancy read 0 from the next cycle.
  - A reset mid-transfer discards all content.
- Push latency: data presented with store_* at edge N is visible on rx_data/tx_packet_data and counted in occupancy after edge N.
- Pop latency: the popped bytes are sampled combinationally before edge N (this is what the AHB slave registers into hrdata). After edge N the head has advanced.
- Wrap-around is seamless: a 4-byte access straddling index DEPTH−1 → 0 uses mem[62], mem[63], mem[0], mem[1].
- Full: count = 64; pushes are dropped with an overflow pulse unless matching pops occur in the same cycle.

## Structure
- Shared package holds:
  - BUF_DEPTH = 64 and the occupancy width.
  - A typedef enum for the 2-bit size code (SZ_NONE, SZ_1, SZ_2, SZ_4).
  - A function mapping a size code to a byte count.
- One sub-module is natural: buffer_byte_lanes. It is purely combinational and maps rd_ptr/count to the 4-byte show-ahead window with zero fill. Pointer/count control stays in data_buffer.

## Test plan
- Reset, then AHB store size 3 with tx_data=0x44332211 -> occupancy 4, rx_data 0x44332211, tx_packet_data 0x11.
- Store 0xDDCCBBAA (size 3), then AHB get size 1 -> rx_data was 0xDDCCBBAA before the edge, becomes 0x00DDCCBB after; occupancy 4→3.
- Fill 62 bytes, then store size 3 -> 2 bytes accepted, occupancy 64, buffer_overflow high for exactly one cycle; later reads wrap through index 63→0 in order.
- USB push 0x5A with simultaneous AHB pop size 2 at occupancy 1 -> one byte popped, 0x5A accepted, occupancy 1, head 0x5A.
- Occupancy 10, assert clear together with store size 3 -> occupancy 0 next cycle, rx_data 0, no overflow pulse.
- Occupancy 3, AHB get size 1 with get_tx_packet_data also high -> occupancy 2; the USB pop is ignored.
